// File: rtl/tb_rd_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// tb_rd_mem_arb_pkg
// Shared types and default widths for the testbench read-memory arbiter.
// Contents:
//   arb_state_t   - per-requester sequencer state (IDLE, RUN, DRAIN, DONE)
//   DefNumReq     - default number of requester streams
//   DefDataWidth  - default memory word width
//   DefAddrWidth  - default address / length width
// -----------------------------------------------------------------------------
package tb_rd_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int DefNumReq    = 2;
  localparam int DefDataWidth = 32;
  localparam int DefAddrWidth = 32;

endpackage

// File: rtl/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Round-robin arbiter: grants the first active request found when scanning
// upwards (with wrap) from the round-robin pointer. The pointer moves to one
// past the granted requester and holds when nothing is granted.
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset (pointer -> 0)
//   req_i        in   [NumReq]  request vector
//   gnt_o        out  [NumReq]  one-hot grant (all zero when no request)
//   gnt_valid_o  out  1         a grant is issued this cycle
//   rr_ptr_o     out  [PtrW]    current round-robin pointer
// -----------------------------------------------------------------------------
module tb_rr_arbiter
  import tb_rd_mem_arb_pkg::*;
#(
  parameter int NumReq = DefNumReq,
  localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              gnt_valid_o,
  output logic [PtrW-1:0]   rr_ptr_o
);

  logic [PtrW-1:0] rr_ptr_q;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] cand;

  // Scan every requester once starting at the pointer; the first active
  // request wins and later candidates are ignored once a grant is found.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx     = '0;
    cand        = '0;
    for (int off = 0; off < NumReq; off++) begin
      cand = PtrW'((int'(rr_ptr_q) + off) % NumReq);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_valid_o = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  // The winner becomes lowest priority next cycle: the pointer lands just
  // past it, wrapping explicitly so non-power-of-two counts work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (gnt_valid_o) begin
      rr_ptr_q <= (int'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: rtl/tb_rd_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_mem_arbiter
// Shares one combinational read-memory port among NumReq streaming consumers.
// Each requester runs its own base/length address sequencer; a round-robin
// arbiter grants at most one read per cycle and the returned word is
// registered into that requester's valid/ready output slot.
// Optional feature macro: TB_RD_MEM_ARB_LOOP_EN (adds loop_en_i; a pass that
// ends with loop_en_i[i] set wraps back to base instead of finishing).
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   start_i      in   [NumReq]             start request, honoured in IDLE only
//   base_addr_i  in   [NumReq][AddrWidth]  first word address, latched on start
//   len_i        in   [NumReq][AddrWidth]  words per pass, latched on start
//   loop_en_i    in   [NumReq]             wrap enable (macro builds only)
//   mem_addr_o   out  [AddrWidth]          shared read address (0 when idle)
//   mem_data_i   in   [DataWidth]          mem[mem_addr_o], same cycle
//   req_data_o   out  [NumReq][DataWidth]  stream data
//   req_valid_o  out  [NumReq]             stream valid
//   req_ready_i  in   [NumReq]             stream ready
//   busy_o       out  [NumReq]             sequencer not IDLE
//   done_o       out  [NumReq]             one-cycle pulse after last word taken
// -----------------------------------------------------------------------------
module tb_rd_mem_arbiter
  import tb_rd_mem_arb_pkg::*;
#(
  parameter int NumReq    = DefNumReq,
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = DefAddrWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                start_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] base_addr_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] len_i,
`ifdef TB_RD_MEM_ARB_LOOP_EN
  input  logic [NumReq-1:0]                loop_en_i,
`endif
  output logic [AddrWidth-1:0]             mem_addr_o,
  input  logic [DataWidth-1:0]             mem_data_i,
  output logic [NumReq-1:0][DataWidth-1:0] req_data_o,
  output logic [NumReq-1:0]                req_valid_o,
  input  logic [NumReq-1:0]                req_ready_i,
  output logic [NumReq-1:0]                busy_o,
  output logic [NumReq-1:0]                done_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]    eligible;
  logic [NumReq-1:0]    gnt;
  logic                 gnt_valid;
  logic [PtrW-1:0]      rr_ptr;
  logic [AddrWidth-1:0] rd_addr [NumReq];

  tb_rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (eligible),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .rr_ptr_o    (rr_ptr)
  );

  for (genvar i = 0; i < NumReq; i++) begin : g_req
    arb_state_t           state_q;
    logic [AddrWidth-1:0] base_q;
    logic [AddrWidth-1:0] len_q;
    logic [AddrWidth-1:0] count_q;
    logic [DataWidth-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 wrap_en;

`ifdef TB_RD_MEM_ARB_LOOP_EN
    assign wrap_en = loop_en_i[i];
`else
    assign wrap_en = 1'b0;
`endif

    // A requester may read only if the word it fetches has somewhere to go:
    // either the slot is empty or its current word leaves this cycle.
    assign eligible[i] = (state_q == RUN) && (!valid_q || req_ready_i[i]);
    assign rd_addr[i]  = base_q + count_q;

    assign req_data_o[i]  = data_q;
    assign req_valid_o[i] = valid_q;
    assign busy_o[i]      = busy_q;
    assign done_o[i]      = done_q;

    // Sequencer plus output slot. The slot loads on a grant and empties on a
    // handshake without a new grant; busy/done are registered alongside the
    // state so they never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        base_q  <= '0;
        len_q   <= '0;
        count_q <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (gnt[i]) begin
          data_q  <= mem_data_i;
          valid_q <= 1'b1;
        end else if (valid_q && req_ready_i[i]) begin
          valid_q <= 1'b0;
        end

        unique case (state_q)
          IDLE: begin
            if (start_i[i]) begin
              base_q  <= base_addr_i[i];
              len_q   <= len_i[i];
              count_q <= '0;
              busy_q  <= 1'b1;
              if (len_i[i] == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            if (gnt[i]) begin
              if (count_q == len_q - AddrWidth'(1)) begin
                if (wrap_en) begin
                  count_q <= '0;
                end else begin
                  count_q <= count_q + AddrWidth'(1);
                  state_q <= DRAIN;
                end
              end else begin
                count_q <= count_q + AddrWidth'(1);
              end
            end
          end
          DRAIN: begin
            if (!valid_q || req_ready_i[i]) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Address mux: the granted requester drives the shared port, otherwise 0.
  always_comb begin
    mem_addr_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_valid && gnt[i]) begin
        mem_addr_o = rd_addr[i];
      end
    end
  end

  // Sanity: never more than one read per cycle and the pointer stays in range.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   $onehot0(gnt) && (int'(rr_ptr) < NumReq));

endmodule
